ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Load/store access controller that sits directly upstream of the core's dual-port data RAM (1-cycle registered read, full-word write only). It accepts byte-addressed load/store requests from the pipeline and drives the RAM write and read ports. Sub-word stores are executed as read-modify-write sequences. Load data is lane-extracted and sign- or zero-extended before it is returned.

## Interface
- AW, 12: RAM word-address width. Byte address is AW+2 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  in  AW+2  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response pulse. No backpressure.
- rsp_rdata_o  out  32  load result. 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal-size request.
- ram_w_en_o  out  1  RAM write enable.
- ram_w_addr_o  out  AW  RAM write word address.
- ram_w_data_o  out  32  RAM write data.
- ram_r_en_o  out  1  RAM read enable.
- ram_r_addr_o  out  AW  RAM read word address.
- ram_r_data_i  in  32  RAM read data, valid the cycle after ram_r_en_o.

## Operation
- States: IDLE, LOAD, MERGE. Reset state is IDLE.
- A request is accepted when req_valid_i && req_ready_o. req_ready_o = 1 only in IDLE with rst high.
- On acceptance, the controller registers the word address req_addr_i[AW+1:2], byte offset addr[1:0], size, unsigned flag and wdata.
- Error check on acceptance:
  - half with addr[0]=1, word with addr[1:0]≠0, or size 11 is an error.
  - An error issues no RAM enable and stays in IDLE.
  - Next cycle: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
- Aligned SW:
  - Acceptance cycle: ram_w_en_o=1, word address, req_wdata_i (combinational). Stays in IDLE.
  - Next cycle: rsp_valid_o=1, err=0.
- Load (any size):
  - Acceptance cycle: ram_r_en_o=1 with word address. Go to LOAD.
  - LOAD: extract the lane from ram_r_data_i, extend it, and register it into rsp_rdata_o. rsp_valid_o=1 the following cycle. Return to IDLE.
- Lane rules:
  - Byte lane = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
  - Sign bit is the lane MSB, unless req_unsigned_i is set.
- SB/SH:
  - Acceptance cycle: ram_r_en_o=1. Go to MERGE.
  - MERGE: ram_w_en_o=1. ram_w_data_o = ram_r_data_i with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged. Same word address.
  - rsp_valid_o=1 the following cycle. Return to IDLE.
- ram_w_en_o and ram_r_en_o are never both driven by the same request in the same cycle.
- All RAM enables are forced to 0 while rst is low.

## Timing
- Reset values: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. req_ready_o=0 and RAM enables=0 while rst is low.
- Latency, accept cycle N to rsp_valid_o:
  - SW and error: N+1.
  - Loads and SB/SH: N+2.
- Throughput:
  - SW and error: 1 per cycle.
  - Loads and SB/SH: 1 per 2 cycles; req_ready_o=0 in LOAD and MERGE.
- A response and a new acceptance may coincide in the same cycle.
- Load at N+1 to a word written by SW at N returns the new data, because the RAM commits the write at the end of N.
- Reset mid-operation: a reset asserted during LOAD or MERGE aborts the access immediately.
  - No RAM write is issued; the memory word is unchanged.
  - No response is produced. The controller returns to IDLE.

## Test plan
- Reset: hold rst low with req_valid_i=1 -> req_ready_o=0, both RAM enables 0, rsp_* all 0. Release rst -> req_ready_o=1 in IDLE.
- Word round trip: SW 0x010 data 0xDEADBEEF, then LW 0x010 -> SW response at N+1 with err=0. Load response at N+2 with rsp_rdata_o=0xDEADBEEF. Back-to-back SWs accepted every cycle.
- Byte RMW: word 0x010 holds 0x11223344. SB 0x013 data 0x80 -> RAM word becomes 0x80223344 after MERGE. LB 0x013 returns 0xFFFFFF80. LBU 0x013 returns 0x00000080.
- Half RMW: word 0x010 holds 0x11223344. SH 0x012 data 0xABCD -> word 0xABCD3344. LH 0x012 returns 0xFFFFABCD. LHU 0x012 returns 0x0000ABCD. LH 0x010 returns 0x00003344.
- Errors: LW 0x011, SH 0x013, size 11 -> each gives rsp_err_o=1 and rsp_rdata_o=0 at N+1. No RAM enable is ever asserted. Memory is unchanged.
- Reset during RMW: pull rst low in the MERGE cycle of SB 0x010 -> no write. LW 0x010 after reset release returns the original word. No stray rsp_valid_o.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Load/store access controller in front of a dual-port data RAM with 1-cycle registered reads.
// Sub-word stores become read-modify-write; loads are lane-extracted and sign/zero-extended.
module ram_access_ctrl #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW+1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          rsp_valid_o,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          ram_w_en_o,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [31:0]   ram_w_data_o,
  output logic          ram_r_en_o,
  output logic [AW-1:0] ram_r_addr_o,
  input  logic [31:0]   ram_r_data_i
);

  typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_wdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_accept;
  logic          w_err;
  logic          w_store_word;
  logic [4:0]    w_shamt;
  logic [31:0]   w_rd_shift;
  logic [31:0]   w_load_val;
  logic [31:0]   w_mask;
  logic [31:0]   w_merged;

  assign req_ready_o = (r_state == IDLE) && rst;
  assign w_accept    = req_valid_i && req_ready_o;

  assign w_err = (req_size_i == 2'b11) ||
                 ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                 ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

  assign w_store_word = req_we_i && (req_size_i == SZ_WORD);

  // Only aligned word stores write directly; everything else legal reads first.
  assign ram_r_en_o   = w_accept && !w_err && !w_store_word;
  assign ram_r_addr_o = req_addr_i[AW+1:2];
  assign ram_w_en_o   = rst && ((w_accept && !w_err && w_store_word) || (r_state == MERGE));
  assign ram_w_addr_o = (r_state == MERGE) ? r_addr : req_addr_i[AW+1:2];
  assign ram_w_data_o = (r_state == MERGE) ? w_merged : req_wdata_i;

  assign w_shamt    = {r_off, 3'b000};
  assign w_rd_shift = ram_r_data_i >> w_shamt;

  always_comb begin
    w_load_val = ram_r_data_i;
    w_mask     = 32'hFFFF_FFFF;
    case (r_size)
      SZ_BYTE: begin
        w_load_val = {{24{!r_uns && w_rd_shift[7]}}, w_rd_shift[7:0]};
        w_mask     = 32'h0000_00FF << w_shamt;
      end
      SZ_HALF: begin
        w_load_val = {{16{!r_uns && w_rd_shift[15]}}, w_rd_shift[15:0]};
        w_mask     = 32'h0000_FFFF << w_shamt;
      end
      default: ;
    endcase
  end

  assign w_merged = (ram_r_data_i & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  // Reset drops any in-flight LOAD/MERGE without a write or response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr_i[AW+1:2];
            r_off   <= req_addr_i[1:0];
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_wdata <= req_wdata_i;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (w_store_word) begin
              r_rsp_valid <= 1'b1;
            end else if (!req_we_i) begin
              r_state <= LOAD;
            end else begin
              r_state <= MERGE;
            end
          end
        end
        LOAD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load_val;
          r_state     <= IDLE;
        end
        MERGE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard testbench for ram_access_ctrl with a behavioural dual-port RAM model.
module tb_ram_access_ctrl;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [AW+1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          ram_w_en_o;
  logic [AW-1:0] ram_w_addr_o;
  logic [31:0]   ram_w_data_o;
  logic          ram_r_en_o;
  logic [AW-1:0] ram_r_addr_o;
  logic [31:0]   ram_r_data_i;

  ram_access_ctrl #(.AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .ram_w_en_o     (ram_w_en_o),
    .ram_w_addr_o   (ram_w_addr_o),
    .ram_w_data_o   (ram_w_data_o),
    .ram_r_en_o     (ram_r_en_o),
    .ram_r_addr_o   (ram_r_addr_o),
    .ram_r_data_i   (ram_r_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    ram_r_data_i = 32'h0;
  end

  // RAM model: writes commit at the clock edge, reads return a cycle later.
  always @(posedge clk) begin
    if (ram_w_en_o) mem[ram_w_addr_o] <= ram_w_data_o;
    if (ram_r_en_o) ram_r_data_i <= mem[ram_r_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor pops one expectation per response and checks timing, error and data.
  always @(negedge clk) begin
    if (rst && rsp_valid_o) begin
      if (expQ.size() == 0) begin
        checkOutput("stray_rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_cycle", cyc, e.cyc);
        checkOutput("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
        checkOutput("rsp_rdata", rsp_rdata_o, e.data);
      end
    end
  end

  // Issues one request; latency and expected RAM enables follow from the request kind.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [13:0] addr, input logic [31:0] wdata,
                               input logic expErr, input logic [31:0] expData);
    exp_t e;
    int   waited;
    logic expW;
    logic expR;
    int   lat;
    waited = 0;
    while (!req_ready_o && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready_o) checkOutput("ready_timeout", 32'd0, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    expW = !expErr && we && (size == 2'b10);
    expR = !expErr && !expW;
    lat  = (expErr || expW) ? 1 : 2;
    e.cyc  = cyc + lat;
    e.err  = expErr;
    e.data = expData;
    expQ.push_back(e);
    #1;
    checkOutput("ram_w_en", {31'd0, ram_w_en_o}, {31'd0, expW});
    checkOutput("ram_r_en", {31'd0, ram_r_en_o}, {31'd0, expR});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 32'd0);
      expQ.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst            = 1'b0;
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'b10;
    req_unsigned_i = 1'b0;
    req_addr_i     = 14'h010;
    req_wdata_i    = 32'h0BAD_0BAD;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, req_ready_o}, 32'd0);
    checkOutput("rst_w_en", {31'd0, ram_w_en_o}, 32'd0);
    checkOutput("rst_r_en", {31'd0, ram_r_en_o}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

    // Word round trip, load immediately after store, back-to-back stores.
    applyStimulus(1, 2'b10, 0, 14'h010, 32'hDEADBEEF, 0, 32'h0);
    applyStimulus(0, 2'b10, 0, 14'h010, 32'h0,        0, 32'hDEADBEEF);
    applyStimulus(1, 2'b10, 0, 14'h020, 32'hA5A5_5A5A, 0, 32'h0);
    applyStimulus(1, 2'b10, 0, 14'h024, 32'h1234_5678, 0, 32'h0);
    applyStimulus(0, 2'b10, 0, 14'h020, 32'h0,        0, 32'hA5A5_5A5A);
    applyStimulus(0, 2'b10, 0, 14'h024, 32'h0,        0, 32'h1234_5678);
    drain();

    // Byte read-modify-write and byte loads.
    applyStimulus(1, 2'b10, 0, 14'h010, 32'h1122_3344, 0, 32'h0);
    applyStimulus(1, 2'b00, 0, 14'h013, 32'hFFFF_FF80, 0, 32'h0);
    drain();
    checkOutput("mem_after_sb", mem[4], 32'h8022_3344);
    applyStimulus(0, 2'b00, 0, 14'h013, 32'h0, 0, 32'hFFFF_FF80);
    applyStimulus(0, 2'b00, 1, 14'h013, 32'h0, 0, 32'h0000_0080);
    applyStimulus(0, 2'b00, 0, 14'h010, 32'h0, 0, 32'h0000_0044);
    applyStimulus(0, 2'b00, 0, 14'h012, 32'h0, 0, 32'h0000_0022);
    drain();

    // Half read-modify-write and half loads.
    applyStimulus(1, 2'b10, 0, 14'h010, 32'h1122_3344, 0, 32'h0);
    applyStimulus(1, 2'b01, 0, 14'h012, 32'h0000_ABCD, 0, 32'h0);
    drain();
    checkOutput("mem_after_sh", mem[4], 32'hABCD_3344);
    applyStimulus(0, 2'b01, 0, 14'h012, 32'h0, 0, 32'hFFFF_ABCD);
    applyStimulus(0, 2'b01, 1, 14'h012, 32'h0, 0, 32'h0000_ABCD);
    applyStimulus(0, 2'b01, 0, 14'h010, 32'h0, 0, 32'h0000_3344);
    drain();

    // Misaligned and illegal-size requests.
    applyStimulus(0, 2'b10, 0, 14'h011, 32'h0,        1, 32'h0);
    applyStimulus(1, 2'b01, 0, 14'h013, 32'h0000_1111, 1, 32'h0);
    applyStimulus(0, 2'b11, 0, 14'h014, 32'h0,        1, 32'h0);
    applyStimulus(1, 2'b10, 0, 14'h012, 32'hFFFF_FFFF, 1, 32'h0);
    drain();
    checkOutput("mem_after_err", mem[4], 32'hABCD_3344);

    // Reset in the MERGE cycle of a byte store must abort the write silently.
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = 14'h010;
    req_wdata_i    = 32'h0000_0099;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("abort_w_en", {31'd0, ram_w_en_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mem_after_abort", mem[4], 32'hABCD_3344);
    applyStimulus(0, 2'b10, 0, 14'h010, 32'h0, 0, 32'hABCD_3344);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
